bcd_converter: RTL and testbench

BCD_CONVERTER -- requirements
Module: bcd_converter

---
 rtl/bcd_converter.sv | 145 ++++++++++++++
 tb/tb_bcd_converter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_converter
//  Description : Converts an 8-bit unsigned operand into three display digits.
//                Decimal mode runs a serial double-dabble (shift-and-add-3)
//                over 8 clocks; hex mode splits the operand into nibbles in
//                a single clock. The digit outputs are registered and only
//                change on the final load edge, so a downstream scan stage
//                never sees intermediate values.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1  rising-edge clock
//    reset_n   in   1  asynchronous active-low reset
//    start     in   1  conversion request, accepted only while idle
//    value     in   8  unsigned binary operand, captured on acceptance
//    hex_mode  in   1  1 = hex digits, 0 = decimal digits, captured with value
//    digitL    out  4  hundreds (decimal) or 0 (hex)
//    digitM    out  4  tens (decimal) or value[7:4] (hex)
//    digitR    out  4  ones (decimal) or value[3:0] (hex)
//    busy      out  1  high while a conversion is in progress
//    done      out  1  one-cycle pulse when new digits first appear
// ============================================================================
module bcd_converter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] value,
  input  logic       hex_mode,
  output logic [3:0] digitL,
  output logic [3:0] digitM,
  output logic [3:0] digitR,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  // [19:8] hold the hundreds/tens/ones BCD nibbles, [7:0] the binary operand
  // still to be shifted in.
  logic [19:0] shift_reg;
  logic [19:0] shift_adj;
  logic [2:0]  iter_cnt;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = hex_mode ? LOAD : SHIFT;
        end
      end
      SHIFT: begin
        // Counter value 7 marks the eighth iteration; leave without an
        // extra cycle.
        if (iter_cnt == 3'd7) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
  // so that it carries correctly into the next decade after doubling.
  // --------------------------------------------------------------------------
  always_comb begin
    shift_adj = shift_reg;
    for (int i = 0; i < 3; i++) begin
      if (shift_reg[8 + 4*i +: 4] >= 4'd5) begin
        shift_adj[8 + 4*i +: 4] = shift_reg[8 + 4*i +: 4] + 4'd3;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= 20'd0;
      iter_cnt  <= 3'd0;
      digitL    <= 4'd0;
      digitM    <= 4'd0;
      digitR    <= 4'd0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Hex operands are placed directly into the digit field so the
            // LOAD step is identical for both modes.
            shift_reg <= hex_mode ? {4'd0, value, 8'd0} : {12'd0, value};
            iter_cnt  <= 3'd0;
          end
        end
        SHIFT: begin
          shift_reg <= shift_adj << 1;
          iter_cnt  <= iter_cnt + 3'd1;
        end
        LOAD: begin
          digitL <= shift_reg[19:16];
          digitM <= shift_reg[15:12];
          digitR <= shift_reg[11:8];
          done   <= 1'b1;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_converter
//  Description : Self-checking bench for bcd_converter. Directed cases plus
//                randomized conversions and full sweeps in both modes, with
//                expected digits computed arithmetically from the operand.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports       : none (top-level bench)
// ============================================================================
module tb_bcd_converter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] value;
  logic       hex_mode;
  logic [3:0] digitL;
  logic [3:0] digitM;
  logic [3:0] digitR;
  logic       busy;
  logic       done;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [11:0] prev_digits = 12'd0;

  always #5 clk = ~clk;

  bcd_converter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .value    (value),
    .hex_mode (hex_mode),
    .digitL   (digitL),
    .digitM   (digitM),
    .digitR   (digitR),
    .busy     (busy),
    .done     (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operand.
  function automatic logic [11:0] ref_digits(input logic [7:0] v, input logic hx);
    int iv;
    iv = int'(v);
    if (hx) return {4'd0, 4'(iv / 16), 4'(iv % 16)};
    return {4'(iv / 100), 4'((iv / 10) % 10), 4'(iv % 10)};
  endfunction

  // One conversion from idle. With noise set, inputs are scrambled while busy
  // (including a start with value 45 at the third edge after acceptance).
  task automatic convert(input logic [7:0] v, input logic hx, input bit noise, input string tag);
    logic [11:0] exp_d;
    int          lat;
    int          n;
    exp_d    = ref_digits(v, hx);
    lat      = hx ? 1 : 9;
    n        = 0;
    start    = 1'b1;
    value    = v;
    hex_mode = hx;
    tick;
    check({tag, "_busy_after_accept"}, busy, 1);
    while (!done && n < 20) begin
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        value    = 8'($urandom);
        hex_mode = 1'($urandom_range(0, 1));
        if (n == 2) begin
          start    = 1'b1;
          value    = 8'd45;
          hex_mode = 1'b0;
        end
      end else begin
        start = 1'b0;
      end
      tick;
      n++;
      if (!done) begin
        check({tag, "_busy_during"}, busy, 1);
        check({tag, "_digits_hold"}, {digitL, digitM, digitR}, prev_digits);
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, n, lat);
    check({tag, "_digits"}, {digitL, digitM, digitR}, exp_d);
    check({tag, "_busy_at_done"}, busy, 0);
    prev_digits = exp_d;
    tick;
    check({tag, "_done_single"}, done, 0);
    check({tag, "_idle_after"}, busy, 0);
  endtask

  // Start held high across all 256 operands; measures done-to-done spacing.
  task automatic sweep(input logic hx);
    int last_done;
    int n;
    start     = 1'b1;
    hex_mode  = hx;
    value     = 8'd0;
    last_done = 0;
    tick;
    for (int v = 0; v < 256; v++) begin
      n = 0;
      while (!done && n < 20) begin
        tick;
        n++;
      end
      check(hx ? "sweep_hex_digits" : "sweep_dec_digits",
            {digitL, digitM, digitR}, ref_digits(8'(v), hx));
      if (v > 0) begin
        check(hx ? "sweep_hex_spacing" : "sweep_dec_spacing",
              cyc - last_done, hx ? 2 : 10);
      end
      last_done = cyc;
      if (v == 255) begin
        start = 1'b0;
      end else begin
        value = 8'(v + 1);
      end
      tick;
    end
    start       = 1'b0;
    prev_digits = ref_digits(8'd255, hx);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    value    = 8'd0;
    hex_mode = 1'b0;
    #2;
    check("reset_digitL", digitL, 0);
    check("reset_digitM", digitM, 0);
    check("reset_digitR", digitR, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    tick;
    tick;
    @(negedge clk);
    reset_n = 1'b1;
    tick;
    check("idle_busy", busy, 0);

    convert(8'd255, 1'b0, 1'b0, "dec255");
    convert(8'd0,   1'b0, 1'b0, "dec0");
    convert(8'd99,  1'b0, 1'b0, "dec99");
    convert(8'd100, 1'b0, 1'b0, "dec100");
    convert(8'd9,   1'b0, 1'b0, "dec9");
    convert(8'hA7,  1'b1, 1'b0, "hexA7");
    convert(8'hFF,  1'b1, 1'b0, "hexFF");
    convert(8'd123, 1'b0, 1'b1, "dec123_ignore");

    // Abort a conversion of 200 with reset four edges after acceptance.
    start    = 1'b1;
    value    = 8'd200;
    hex_mode = 1'b0;
    tick;
    start = 1'b0;
    repeat (4) tick;
    reset_n = 1'b0;
    #1;
    check("abort_digits", {digitL, digitM, digitR}, 12'h000);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    tick;
    check("abort_done_held", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      check("abort_no_done", done, 0);
      check("abort_digits_stay", {digitL, digitM, digitR}, 12'h000);
    end
    prev_digits = 12'h000;
    convert(8'd200, 1'b0, 1'b0, "after_abort200");

    for (int i = 0; i < 30; i++) begin
      convert(8'($urandom), 1'($urandom_range(0, 1)), 1'b1, "random");
    end

    sweep(1'b0);
    sweep(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
